exc_unit: RTL and testbench

EXC_UNIT -- requirements
Module: exc_unit

---
 rtl/exc_unit.sv | 163 ++++++++++++++++
 tb/tb_exc_unit.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/exc_unit.sv
// Exception/eret redirect unit: picks the MEM-stage event, builds CP0 update values, flushes.
// Optional build macro EXC_CP0_FWD_EN forwards a pending WB mtc0 into the effective CP0 values.
module exc_unit #(
    parameter logic [31:0] EXC_VECTOR    = 32'h0000_0020,
    parameter int          REFILL_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_valid,
    input  logic [31:0] mem_pc,
    input  logic [4:0]  mem_exc,
    input  logic        mem_in_ds,
    input  logic [31:0] cp0_status,
    input  logic [31:0] cp0_cause,
    input  logic [31:0] cp0_epc,
    input  logic        wb_cp0_we,
    input  logic [4:0]  wb_cp0_waddr,
    input  logic [31:0] wb_cp0_wdata,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic        exc_we,
    output logic [31:0] exc_epc,
    output logic [31:0] exc_cause,
    output logic [31:0] exc_status
);
    localparam logic [2:0] REFILL_CNT = 3'(REFILL_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_REDIRECT, S_REFILL} state_t;

    state_t      r_state, w_state_next;
    logic [2:0]  r_cnt, w_cnt_next;
    logic        r_flush, w_flush_next;
    logic        r_exc_we, w_exc_we_next;
    logic [31:0] r_new_pc, w_new_pc_next;
    logic [31:0] r_epc, w_epc_next;
    logic [31:0] r_cause, w_cause_next;
    logic [31:0] r_status, w_status_next;

    logic [31:0] w_eff_status, w_eff_cause, w_eff_epc;
    logic        w_int;
    logic        w_exc_any;
    logic [4:0]  w_code;

`ifdef EXC_CP0_FWD_EN
    always_comb begin
        w_eff_status = cp0_status;
        w_eff_cause  = cp0_cause;
        w_eff_epc    = cp0_epc;
        if (wb_cp0_we && wb_cp0_waddr == 5'd12)
            w_eff_status = wb_cp0_wdata;
        // Only the software-writable cause bits (IP1:IP0, IV, WP) are overlaid
        if (wb_cp0_we && wb_cp0_waddr == 5'd13) begin
            w_eff_cause[9:8] = wb_cp0_wdata[9:8];
            w_eff_cause[23]  = wb_cp0_wdata[23];
            w_eff_cause[22]  = wb_cp0_wdata[22];
        end
        if (wb_cp0_we && wb_cp0_waddr == 5'd14)
            w_eff_epc = wb_cp0_wdata;
    end
`else
    logic w_unused_wb;
    assign w_unused_wb  = ^{wb_cp0_we, wb_cp0_waddr, wb_cp0_wdata};
    assign w_eff_status = cp0_status;
    assign w_eff_cause  = cp0_cause;
    assign w_eff_epc    = cp0_epc;
`endif

    assign w_int     = w_eff_status[0] & ~w_eff_status[1]
                     & (|(w_eff_cause[15:8] & w_eff_status[15:8]));
    assign w_exc_any = w_int | (|mem_exc[3:0]);

    always_comb begin
        if (w_int)           w_code = 5'd0;
        else if (mem_exc[0]) w_code = 5'd8;
        else if (mem_exc[1]) w_code = 5'd9;
        else if (mem_exc[2]) w_code = 5'd10;
        else                 w_code = 5'd12;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= 3'd0;
            r_flush  <= 1'b0;
            r_exc_we <= 1'b0;
            r_new_pc <= 32'd0;
            r_epc    <= 32'd0;
            r_cause  <= 32'd0;
            r_status <= 32'd0;
        end else begin
            r_state  <= w_state_next;
            r_cnt    <= w_cnt_next;
            r_flush  <= w_flush_next;
            r_exc_we <= w_exc_we_next;
            r_new_pc <= w_new_pc_next;
            r_epc    <= w_epc_next;
            r_cause  <= w_cause_next;
            r_status <= w_status_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_cnt_next    = r_cnt;
        w_flush_next  = 1'b0;
        w_exc_we_next = 1'b0;
        w_new_pc_next = r_new_pc;
        w_epc_next    = r_epc;
        w_cause_next  = r_cause;
        w_status_next = r_status;
        case (r_state)
            S_IDLE: begin
                if (mem_valid && w_exc_any) begin
                    w_state_next  = S_REDIRECT;
                    w_flush_next  = 1'b1;
                    w_exc_we_next = 1'b1;
                    w_new_pc_next = EXC_VECTOR;
                    w_status_next = w_eff_status | 32'h0000_0002;
                    w_cause_next  = w_eff_cause;
                    w_cause_next[6:2] = w_code;
                    // Nested exception under EXL keeps the original EPC and BD
                    if (w_eff_status[1]) begin
                        w_epc_next = w_eff_epc;
                    end else begin
                        w_epc_next = mem_in_ds ? (mem_pc - 32'd4) : mem_pc;
                        w_cause_next[31] = mem_in_ds;
                    end
                end else if (mem_valid && mem_exc[4]) begin
                    w_state_next  = S_REDIRECT;
                    w_flush_next  = 1'b1;
                    w_exc_we_next = 1'b1;
                    w_new_pc_next = w_eff_epc;
                    w_status_next = w_eff_status & ~32'h0000_0002;
                    w_cause_next  = w_eff_cause;
                    w_epc_next    = w_eff_epc;
                end
            end
            S_REDIRECT: begin
                w_state_next = S_REFILL;
                w_cnt_next   = REFILL_CNT;
            end
            S_REFILL: begin
                if (r_cnt <= 3'd1) begin
                    w_state_next = S_IDLE;
                    w_cnt_next   = 3'd0;
                end else begin
                    w_cnt_next = r_cnt - 3'd1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_cnt_next   = 3'd0;
            end
        endcase
    end

    assign flush      = r_flush;
    assign exc_we     = r_exc_we;
    assign new_pc     = r_new_pc;
    assign exc_epc    = r_epc;
    assign exc_cause  = r_cause;
    assign exc_status = r_status;
endmodule

// File: tb/tb_exc_unit.sv
// Directed-vector bench for exc_unit with hand-computed expectations.
module tb_exc_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_valid;
    logic [31:0] mem_pc;
    logic [4:0]  mem_exc;
    logic        mem_in_ds;
    logic [31:0] cp0_status, cp0_cause, cp0_epc;
    logic        wb_cp0_we;
    logic [4:0]  wb_cp0_waddr;
    logic [31:0] wb_cp0_wdata;
    logic        flush, exc_we;
    logic [31:0] new_pc, exc_epc, exc_cause, exc_status;

    int n_vec = 0;
    int n_err = 0;

    localparam logic [4:0] X_SYS  = 5'b00001;
    localparam logic [4:0] X_BRK  = 5'b00010;
    localparam logic [4:0] X_RI   = 5'b00100;
    localparam logic [4:0] X_OV   = 5'b01000;
    localparam logic [4:0] X_ERET = 5'b10000;

`ifdef EXC_CP0_FWD_EN
    localparam logic [31:0] ERET_PC = 32'h0000_0300;
`else
    localparam logic [31:0] ERET_PC = 32'h0000_0080;
`endif

    exc_unit dut (
        .clk(clk), .rst_n(rst_n),
        .mem_valid(mem_valid), .mem_pc(mem_pc), .mem_exc(mem_exc), .mem_in_ds(mem_in_ds),
        .cp0_status(cp0_status), .cp0_cause(cp0_cause), .cp0_epc(cp0_epc),
        .wb_cp0_we(wb_cp0_we), .wb_cp0_waddr(wb_cp0_waddr), .wb_cp0_wdata(wb_cp0_wdata),
        .flush(flush), .new_pc(new_pc), .exc_we(exc_we),
        .exc_epc(exc_epc), .exc_cause(exc_cause), .exc_status(exc_status)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic go_idle();
        mem_valid = 1'b0;
        mem_exc   = 5'b0;
        mem_in_ds = 1'b0;
        repeat (4) tick();
    endtask

    task automatic offer(input logic [4:0] exc, input logic [31:0] pc, input logic ds);
        mem_valid = 1'b1;
        mem_exc   = exc;
        mem_pc    = pc;
        mem_in_ds = ds;
    endtask

    initial begin
        rst_n = 1'b0; mem_valid = 1'b0; mem_pc = 32'd0; mem_exc = 5'd0; mem_in_ds = 1'b0;
        cp0_status = 32'd0; cp0_cause = 32'd0; cp0_epc = 32'd0;
        wb_cp0_we = 1'b0; wb_cp0_waddr = 5'd0; wb_cp0_wdata = 32'd0;
        tick(); tick();
        chk("rst_flush", {31'd0, flush}, 32'd0);
        chk("rst_exc_we", {31'd0, exc_we}, 32'd0);
        chk("rst_new_pc", new_pc, 32'd0);
        chk("rst_epc", exc_epc, 32'd0);
        chk("rst_cause", exc_cause, 32'd0);
        chk("rst_status", exc_status, 32'd0);
        rst_n = 1'b1;
        tick();

        // syscall, not in delay slot
        cp0_status = 32'h1;
        offer(X_SYS, 32'h100, 1'b0);
        tick();
        chk("sys_flush", {31'd0, flush}, 32'd1);
        chk("sys_we", {31'd0, exc_we}, 32'd1);
        chk("sys_new_pc", new_pc, 32'h20);
        chk("sys_epc", exc_epc, 32'h100);
        chk("sys_cause", exc_cause, 32'h20);
        chk("sys_status", exc_status, 32'h3);
        mem_valid = 1'b0;
        tick();
        chk("sys_flush_1cyc", {31'd0, flush}, 32'd0);
        chk("sys_we_1cyc", {31'd0, exc_we}, 32'd0);
        chk("sys_pc_hold", new_pc, 32'h20);
        go_idle();

        // syscall in delay slot
        offer(X_SYS, 32'h204, 1'b1);
        tick();
        chk("ds_epc", exc_epc, 32'h200);
        chk("ds_cause", exc_cause, 32'h8000_0020);
        go_idle();

        // interrupt outranks overflow
        cp0_status = 32'h0000_0401; cp0_cause = 32'h0000_0400;
        offer(X_OV, 32'h300, 1'b0);
        tick();
        chk("int_flush", {31'd0, flush}, 32'd1);
        chk("int_cause", exc_cause, 32'h0000_0400);
        chk("int_status", exc_status, 32'h0000_0403);
        chk("int_epc", exc_epc, 32'h300);
        go_idle();

        // EXL set masks the interrupt
        cp0_status = 32'h0000_0403;
        offer(5'b0, 32'h310, 1'b0);
        tick();
        chk("exl_noint_flush", {31'd0, flush}, 32'd0);
        chk("exl_noint_we", {31'd0, exc_we}, 32'd0);
        chk("exl_noint_pc", new_pc, 32'h20);
        go_idle();

        // overflow under EXL keeps EPC and BD
        cp0_status = 32'h3; cp0_cause = 32'h0; cp0_epc = 32'h555;
        offer(X_OV, 32'h400, 1'b1);
        tick();
        chk("nest_epc", exc_epc, 32'h555);
        chk("nest_cause", exc_cause, 32'h30);
        chk("nest_status", exc_status, 32'h3);
        go_idle();

        // eret with a pending mtc0 to EPC
        cp0_status = 32'h3; cp0_cause = 32'h0; cp0_epc = 32'h80;
        wb_cp0_we = 1'b1; wb_cp0_waddr = 5'd14; wb_cp0_wdata = 32'h300;
        offer(X_ERET, 32'h700, 1'b0);
        tick();
        chk("eret_flush", {31'd0, flush}, 32'd1);
        chk("eret_we", {31'd0, exc_we}, 32'd1);
        chk("eret_new_pc", new_pc, ERET_PC);
        chk("eret_epc", exc_epc, ERET_PC);
        chk("eret_status", exc_status, 32'h1);
        wb_cp0_we = 1'b0;
        go_idle();

        // events during REDIRECT/REFILL are dropped
        cp0_status = 32'h1; cp0_epc = 32'h0;
        offer(X_SYS, 32'h500, 1'b0);
        tick();
        chk("win_first_flush", {31'd0, flush}, 32'd1);
        offer(X_RI, 32'h504, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("win_ignored_flush", {31'd0, flush}, 32'd0);
            chk("win_ignored_we", {31'd0, exc_we}, 32'd0);
        end
        tick();
        chk("win_ri_flush", {31'd0, flush}, 32'd1);
        chk("win_ri_cause", exc_cause, 32'h28);
        chk("win_ri_epc", exc_epc, 32'h504);
        go_idle();

        // reset during REFILL, then a fresh syscall
        offer(X_SYS, 32'h580, 1'b0);
        tick();
        mem_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        chk("mid_rst_flush", {31'd0, flush}, 32'd0);
        chk("mid_rst_we", {31'd0, exc_we}, 32'd0);
        chk("mid_rst_pc", new_pc, 32'd0);
        chk("mid_rst_epc", exc_epc, 32'd0);
        chk("mid_rst_cause", exc_cause, 32'd0);
        chk("mid_rst_status", exc_status, 32'd0);
        rst_n = 1'b1;
        offer(X_SYS, 32'h600, 1'b0);
        tick();
        chk("post_rst_flush", {31'd0, flush}, 32'd1);
        chk("post_rst_pc", new_pc, 32'h20);
        chk("post_rst_epc", exc_epc, 32'h600);
        go_idle();

        // brk beats ri; delay-slot PC wraps
        offer(X_BRK | X_RI, 32'h0, 1'b1);
        tick();
        chk("wrap_epc", exc_epc, 32'hFFFF_FFFC);
        chk("wrap_cause", exc_cause, 32'h8000_0024);
        go_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
